// File: rtl/hilo_mult_if.sv
// Request/response bundle between ID/EX control and the HI/LO multiply sequencer.
// The master side is the pipeline; the slave side is hilo_mult_ctrl.
interface hilo_mult_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic [31:0] hi_in;
  logic [31:0] lo_in;
  logic        mf_req;
  logic        busy;
  logic        done;
  logic        stall;
  logic [63:0] product;
  logic [3:0]  hi_en;
  logic [3:0]  lo_en;

  modport master (
    output start, op, rs, rt, hi_in, lo_in, mf_req,
    input  busy, done, stall, product, hi_en, lo_en
  );

  modport slave (
    input  start, op, rs, rt, hi_in, lo_in, mf_req,
    output busy, done, stall, product, hi_en, lo_en
  );
endinterface

// File: rtl/hilo_mult_ctrl.sv
// Iterative shift-add 32x32 multiply / MADD / MSUB / MTHI / MTLO sequencer driving HI/LO enables.
// Optional macro MUL_EARLY_TERM_EN ends the MUL phase once the remaining multiplier is zero.
module hilo_mult_ctrl #(
  parameter int unsigned BITS_PER_CYC = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  hilo_mult_if.slave  bus
);

  localparam int unsigned MUL_CYCLES = 32 / BITS_PER_CYC;
  localparam logic [5:0]  LAST_CNT   = 6'(MUL_CYCLES - 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_MADD  = 3'd2;
  localparam logic [2:0] OP_MSUB  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {IDLE, MUL, WRITE} state_e;

  state_e      state_q;
  logic [2:0]  op_q;
  logic        sign_q;
  logic [31:0] mplier_q;
  logic [63:0] mcand_q;
  logic [63:0] acc_q;
  logic [63:0] hilo_q;
  logic [5:0]  cnt_q;
  logic        done_q;
  logic [63:0] product_q;
  logic [3:0]  hi_en_q;
  logic [3:0]  lo_en_q;

  logic        signed_op;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;
  logic [63:0] partial;
  logic [63:0] acc_d;
  logic [31:0] mplier_d;
  logic [63:0] mcand_d;
  logic [63:0] prod;
  logic [63:0] result_d;
  logic        mul_last;

  // Signed ops multiply magnitudes; |0x80000000| = 2^31 still fits 32 unsigned bits.
  assign signed_op = (bus.op != OP_MULTU);
  assign rs_mag    = (signed_op && bus.rs[31]) ? -bus.rs : bus.rs;
  assign rt_mag    = (signed_op && bus.rt[31]) ? -bus.rt : bus.rt;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    partial  = mcand_q * 64'(mplier_q[BITS_PER_CYC-1:0]);
    acc_d    = acc_q + partial;
    mplier_d = mplier_q >> BITS_PER_CYC;
    mcand_d  = mcand_q << BITS_PER_CYC;
    prod     = sign_q ? -acc_d : acc_d;
    result_d = prod;
    case (op_q)
      OP_MADD: result_d = hilo_q + prod;
      OP_MSUB: result_d = hilo_q - prod;
      default: result_d = prod;
    endcase
`ifdef MUL_EARLY_TERM_EN
    mul_last = (cnt_q == LAST_CNT) || (mplier_d == '0);
`else
    mul_last = (cnt_q == LAST_CNT);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      op_q      <= '0;
      sign_q    <= 1'b0;
      mplier_q  <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      hilo_q    <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      product_q <= '0;
      hi_en_q   <= '0;
      lo_en_q   <= '0;
    end else begin
      // Write-cycle outputs are single-cycle pulses unless re-armed below.
      done_q    <= 1'b0;
      product_q <= '0;
      hi_en_q   <= '0;
      lo_en_q   <= '0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                state_q  <= MUL;
                op_q     <= bus.op;
                sign_q   <= signed_op & (bus.rs[31] ^ bus.rt[31]);
                mplier_q <= rt_mag;
                mcand_q  <= {32'b0, rs_mag};
                acc_q    <= '0;
                hilo_q   <= {bus.hi_in, bus.lo_in};
                cnt_q    <= '0;
              end
              OP_MTHI: begin
                state_q   <= WRITE;
                op_q      <= bus.op;
                product_q <= {32'b0, bus.rs};
                hi_en_q   <= 4'd2;
                done_q    <= 1'b1;
              end
              OP_MTLO: begin
                state_q   <= WRITE;
                op_q      <= bus.op;
                product_q <= {32'b0, bus.rs};
                lo_en_q   <= 4'd2;
                done_q    <= 1'b1;
              end
              default: state_q <= IDLE;
            endcase
          end
        end
        MUL: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_d;
          mcand_q  <= mcand_d;
          cnt_q    <= cnt_q + 6'd1;
          if (mul_last) begin
            state_q   <= WRITE;
            product_q <= result_d;
            hi_en_q   <= 4'd3;
            lo_en_q   <= 4'd2;
            done_q    <= 1'b1;
          end
        end
        WRITE:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.stall   = bus.mf_req & bus.busy;
  assign bus.done    = done_q;
  assign bus.product = product_q;
  assign bus.hi_en   = hi_en_q;
  assign bus.lo_en   = lo_en_q;

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// Self-checking bench for hilo_mult_ctrl: directed and random ops against an arithmetic HI/LO model.
// Honours MUL_EARLY_TERM_EN when predicting multiply latency.
module tb_hilo_mult_ctrl;
  localparam int unsigned B = 1;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  hilo_mult_if bus ();

  hilo_mult_ctrl #(.BITS_PER_CYC(B)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural result of the op against the current HI/LO contents.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] rs,
                                        input logic [31:0] rt, input logic [31:0] hi,
                                        input logic [31:0] lo);
    logic signed [63:0] a;
    logic signed [63:0] b;
    logic [63:0] s;
    logic [63:0] u;
    a = $signed(rs);
    b = $signed(rt);
    s = a * b;
    u = {32'b0, rs} * {32'b0, rt};
    case (op)
      3'd0:    return s;
      3'd1:    return u;
      3'd2:    return {hi, lo} + s;
      3'd3:    return {hi, lo} - s;
      3'd4:    return {32'b0, rs};
      3'd5:    return {32'b0, rs};
      default: return 64'd0;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] op, input logic [31:0] rt);
    logic [31:0] m;
    int c;
    if (op == 3'd4 || op == 3'd5) return 2;
`ifdef MUL_EARLY_TERM_EN
    m = (op != 3'd1 && rt[31]) ? -rt : rt;
    c = 0;
    do begin
      c++;
      m = m >> B;
    end while (m != 0);
    return c + 2;
`else
    m = rt;
    c = 32 / B;
    return c + 2 + 0 * int'(m[0]);
`endif
  endfunction

  // Issues one op in the current idle cycle, waits for Done, checks it, and updates the HI/LO model.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input bit probe);
    logic [63:0] exp_p;
    logic [3:0]  exp_hi;
    logic [3:0]  exp_lo;
    int n;
    exp_p = model(op, rs, rt, hi_m, lo_m);
    bus.op    = op;
    bus.rs    = rs;
    bus.rt    = rt;
    bus.hi_in = hi_m;
    bus.lo_in = lo_m;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.rs    = $urandom;
    bus.rt    = $urandom;
    bus.hi_in = $urandom;
    bus.lo_in = $urandom;
    if (op > 3'd5) begin
      check({tag, "_ign_busy"}, bus.busy, 64'd0);
      @(posedge clk); #1;
      check({tag, "_ign_done"}, bus.done, 64'd0);
      return;
    end
    check({tag, "_busy"}, bus.busy, 64'd1);
    n = 0;
    while (bus.done !== 1'b1 && n < 200) begin
      if (probe && n == 3) begin
        bus.mf_req = 1'b1;
        bus.start  = 1'b1;
        bus.op     = 3'd5;
        #1;
        check({tag, "_stall"}, bus.stall, 64'd1);
      end
      @(posedge clk); #1;
      n++;
      bus.mf_req = 1'b0;
      bus.start  = 1'b0;
      bus.op     = op;
    end
    exp_hi = (op == 3'd4) ? 4'd2 : (op == 3'd5) ? 4'd0 : 4'd3;
    exp_lo = (op == 3'd4) ? 4'd0 : 4'd2;
    check({tag, "_latency"}, 64'(n + 2), 64'(exp_latency(op, rt)));
    check({tag, "_product"}, bus.product, exp_p);
    check({tag, "_hi_en"}, bus.hi_en, 64'(exp_hi));
    check({tag, "_lo_en"}, bus.lo_en, 64'(exp_lo));
    if (exp_hi == 4'd3) hi_m = exp_p[63:32];
    if (exp_hi == 4'd2) hi_m = exp_p[31:0];
    if (exp_lo == 4'd2) lo_m = exp_p[31:0];
    @(posedge clk); #1;
    check({tag, "_done_drop"}, bus.done, 64'd0);
    check({tag, "_en_drop"}, {bus.hi_en, bus.lo_en}, 64'd0);
    check({tag, "_idle"}, bus.busy, 64'd0);
  endtask

  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_rs;
    logic [31:0] r_rt;
    errors = 0;
    checks = 0;
    hi_m   = '0;
    lo_m   = '0;
    rst    = 1'b1;
    bus.start  = 1'b0;
    bus.op     = '0;
    bus.rs     = '0;
    bus.rt     = '0;
    bus.hi_in  = '0;
    bus.lo_in  = '0;
    bus.mf_req = 1'b0;
    #2;
    check("reset_busy", bus.busy, 64'd0);
    check("reset_done", bus.done, 64'd0);
    check("reset_product", bus.product, 64'd0);
    check("reset_en", {bus.hi_en, bus.lo_en}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    bus.mf_req = 1'b1;
    #1;
    check("idle_stall", bus.stall, 64'd0);
    bus.mf_req = 1'b0;

    do_op("mult_neg3x7", 3'd0, -32'sd3, 32'd7, 1'b1);
    do_op("multu_ones", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op("mult_ones", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    hi_m = 32'h0;
    lo_m = 32'hFFFF_FFFF;
    do_op("madd_carry", 3'd2, 32'd1, 32'd1, 1'b0);
    do_op("msub_borrow", 3'd3, 32'd1, 32'd1, 1'b1);
    do_op("mthi", 3'd4, 32'hDEAD_BEEF, 32'd0, 1'b0);
    do_op("mtlo", 3'd5, 32'h1234_5678, 32'd0, 1'b0);
    do_op("mult_min", 3'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    do_op("mult_rt0", 3'd0, 32'h1357_9BDF, 32'd0, 1'b0);
    do_op("mult_rt2", 3'd0, 32'h0BAD_F00D, 32'd2, 1'b0);
    do_op("op6", 3'd6, 32'd5, 32'd5, 1'b0);
    do_op("op7", 3'd7, 32'd5, 32'd5, 1'b0);

    // Abort a multiply mid-flight; HI/LO must not be written.
    bus.op    = 3'd0;
    bus.rs    = 32'd100;
    bus.rt    = 32'd200;
    bus.hi_in = hi_m;
    bus.lo_in = lo_m;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", bus.busy, 64'd0);
    check("abort_done", bus.done, 64'd0);
    check("abort_product", bus.product, 64'd0);
    check("abort_en", {bus.hi_en, bus.lo_en}, 64'd0);
    @(posedge clk); #1;
    check("abort_hold_en", {bus.hi_en, bus.lo_en, 3'b0, bus.done}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_quiet", {bus.hi_en, bus.lo_en, 3'b0, bus.done}, 64'd0);
    do_op("after_abort", 3'd0, -32'sd12345, 32'd6789, 1'b0);

    for (int i = 0; i < 24; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_rs = $urandom;
      r_rt = $urandom;
      if (($urandom & 7) == 0) r_rs = 32'h8000_0000;
      if (($urandom & 7) == 1) r_rt = 32'd0;
      if (($urandom & 3) == 2) r_rt = r_rt >> $urandom_range(0, 31);
      do_op($sformatf("rand%0d", i), r_op, r_rs, r_rt, (i % 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
